mef_vedacao: RTL

MEF_VEDACAO -- requirements
Module: mef_vedacao

---
 rtl/mef_vedacao.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mef_vedacao.sv
// mef_vedacao -- bottle capping (cork sealing) controller.
//
// Holds the capping actuator for SEAL_CYCLES clocks per bottle, tracks the
// cork stock, and handshakes with the main line FSM through pos_ve/ve_done.
// A bottle is sealed once; pos_ve must fall before the next seal can begin.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      line enable; low aborts any seal and returns to IDLE
//   pos_ve     bottle present at the sealing position (level)
//   add_corks  one-cycle refill pulse, adds REFILL corks (saturating)
//   seal_act   capping actuator drive (registered)
//   ve_done    seal complete, held until pos_ve falls (registered)
//   no_cork    stock-empty alarm (registered, tracks cork_count == 0)
//   cork_count current cork stock
module mef_vedacao #(
  parameter int unsigned SEAL_CYCLES = 3,
  parameter int unsigned CORK_INIT   = 20,
  parameter int unsigned REFILL      = 15,
  parameter int unsigned CORK_MAX    = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pos_ve,
  input  logic       add_corks,
  output logic       seal_act,
  output logic       ve_done,
  output logic       no_cork,
  output logic [6:0] cork_count
);

  typedef enum logic [1:0] {
    IDLE,
    SEAL,
    DONE,
    WAIT_CORK
  } state_t;

  localparam logic [3:0] TIMER_LAST = 4'(SEAL_CYCLES - 1);
  localparam logic [7:0] REFILL8    = 8'(REFILL);
  localparam logic [6:0] MAX7       = 7'(CORK_MAX);
  localparam logic [6:0] INIT7      = 7'(CORK_INIT);

  state_t     state, state_n;
  logic [3:0] timer, timer_n;
  logic [6:0] count_n;
  logic [7:0] sum;
  logic       dec;

  always_comb begin
    state_n = state;
    timer_n = timer;
    dec     = 1'b0;
    if (!start) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      case (state)
        IDLE: begin
          timer_n = '0;
          if (pos_ve) state_n = (cork_count != '0) ? SEAL : WAIT_CORK;
        end
        SEAL: begin
          if (!pos_ve) begin
            state_n = IDLE;
            timer_n = '0;
          end else if (timer == TIMER_LAST) begin
            state_n = DONE;
            timer_n = '0;
            dec     = (cork_count != '0);
          end else begin
            timer_n = timer + 4'd1;
          end
        end
        DONE: begin
          if (!pos_ve) state_n = IDLE;
        end
        WAIT_CORK: begin
          if (!pos_ve) begin
            state_n = IDLE;
          end else if (cork_count != '0) begin
            state_n = SEAL;
            timer_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = '0;
        end
      endcase
    end

    // Decrement and refill are folded into one sum so a refill landing on
    // the completion edge saturates on (count - 1 + REFILL).
    sum     = {1'b0, cork_count} - {7'd0, dec} + (add_corks ? REFILL8 : 8'd0);
    count_n = (sum > {1'b0, MAX7}) ? MAX7 : sum[6:0];
  end

  // Outputs are registered from the next-state values so they stay Moore
  // outputs of the registered state while avoiding a decode stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      cork_count <= INIT7;
      seal_act   <= 1'b0;
      ve_done    <= 1'b0;
      no_cork    <= (CORK_INIT == 0);
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      cork_count <= count_n;
      seal_act   <= (state_n == SEAL);
      ve_done    <= (state_n == DONE);
      no_cork    <= (count_n == '0);
    end
  end

endmodule
